// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Brief    : Sequential six-digit BCD to binary converter (reverse double dabble)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [3:0]       bit_0,
    input  logic [3:0]       bit_1,
    input  logic [3:0]       bit_2,
    input  logic [3:0]       bit_3,
    input  logic [3:0]       bit_4,
    input  logic [3:0]       bit_5,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] data
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_REG_W = c_BCD_W + BIN_W;
    localparam int c_CNT_W = $clog2(BIN_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_ADJUST = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_REG_W-1:0]   r_work;
    logic [c_CNT_W-1:0]   r_iter_cnt;
    logic                 r_bad_req;

    logic [c_BCD_W-1:0]   w_bcd_in;
    logic [DIGITS-1:0]    w_nib_bad;
    logic [c_BCD_W-1:0]   w_adj_bcd;
    logic                 w_input_ok;
    logic                 w_last;

    assign w_bcd_in = {bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};

    // Per-digit range check on the request and the -3 correction on the working register
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        logic [3:0] w_in_nib;
        logic [3:0] w_cur_nib;
        assign w_in_nib  = w_bcd_in[4*gi +: 4];
        assign w_cur_nib = r_work[BIN_W + 4*gi +: 4];
        assign w_nib_bad[gi] = (w_in_nib > 4'd9);
        assign w_adj_bcd[4*gi +: 4] = (w_cur_nib >= 4'd8) ? (w_cur_nib - 4'd3) : w_cur_nib;
    end

    assign w_input_ok = ~|w_nib_bad;
    assign w_last     = (r_iter_cnt == c_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_input_ok ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT:  w_next = S_ADJUST;
            S_ADJUST: w_next = w_last ? S_DONE : S_SHIFT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_work     <= '0;
            r_iter_cnt <= '0;
            r_bad_req  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            data       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (w_input_ok) begin
                            r_work     <= {w_bcd_in, {BIN_W{1'b0}}};
                            r_iter_cnt <= '0;
                            r_bad_req  <= 1'b0;
                        end else begin
                            r_bad_req  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= {1'b0, r_work[c_REG_W-1:1]};
                end
                S_ADJUST: begin
                    r_work <= {w_adj_bcd, r_work[BIN_W-1:0]};
                    if (!w_last) begin
                        r_iter_cnt <= r_iter_cnt + c_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    // A rejected request keeps the previous result visible
                    if (r_bad_req) begin
                        err  <= 1'b1;
                    end else begin
                        err  <= 1'b0;
                        data <= r_work[BIN_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
